// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM
// state encoding.
package mdu_defs;

  localparam int unsigned OP_W = 3;

  // Operation codes presented on the op port.
  localparam logic [OP_W-1:0] MULT  = 3'd0;
  localparam logic [OP_W-1:0] MULTU = 3'd1;
  localparam logic [OP_W-1:0] DIV   = 3'd2;
  localparam logic [OP_W-1:0] DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MTLO  = 3'd5;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_step.sv
// Single radix-2 iteration of the multiply/divide datapath (combinational).
// Ports:
//   acc_i    upper partial word (product high half / partial remainder)
//   mq_i     lower partial word (multiplier being consumed / dividend bits)
//   opnd_i   multiplicand (multiply) or divisor (divide) magnitude
//   is_div_i 1 = restoring shift-subtract step, 0 = shift-add step
//   acc_o    next upper partial word
//   q_bit_o  bit entering the lower word: quotient bit when dividing,
//            product bit shifted down into the low half when multiplying
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             is_div_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
  always_comb begin
    sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, mq_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};
    acc_o   = sum[WIDTH:1];
    q_bit_o = sum[0];
    if (is_div_i) begin
      q_bit_o = ~diff[WIDTH];
      acc_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU one bit per cycle and services MTHI/MTLO.
// Optional macro MDU_CANCEL_EN adds a cancel input that aborts a running op.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operation handshake (accept on in_valid & in_ready)
//   op, src_a, src_b  operation code and operands
//   busy              iteration in progress
//   done              one-cycle pulse: hi/lo updated at the preceding edge
//   hi, lo            HI/LO registers
//   div0              last divide had a zero divisor (cleared on accept)
//   cancel            (MDU_CANCEL_EN only) abort the running operation
module mul_div_unit
  import mdu_defs::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             div0
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic             in_ready_q, busy_q;

  logic             cancel_c;
  logic             op_legal_c;
  logic             is_signed_c;
  logic             sa_c, sb_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH-1:0] step_acc_c;
  logic             step_bit_c;
  logic [PW-1:0]    prod_c;

`ifdef MDU_CANCEL_EN
  assign cancel_c = cancel;
`else
  assign cancel_c = 1'b0;
`endif

  // Operand magnitudes and signs captured at accept.
  assign op_legal_c  = (op <= MTLO);
  assign is_signed_c = (op == MULT) || (op == DIV);
  assign sa_c        = is_signed_c & src_a[WIDTH-1];
  assign sb_c        = is_signed_c & src_b[WIDTH-1];
  assign mag_a_c     = sa_c ? (WIDTH'(0) - src_a) : src_a;
  assign mag_b_c     = sb_c ? (WIDTH'(0) - src_b) : src_b;
  assign prod_c      = {acc_q, mq_q};

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc_c),
    .q_bit_o  (step_bit_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = div0_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && !cancel_c && op_legal_c) begin
          div0_d = 1'b0;
          if (op == MTHI) begin
            hi_d   = src_a;
            done_d = 1'b1;
          end else if (op == MTLO) begin
            lo_d   = src_a;
            done_d = 1'b1;
          end else begin
            is_div_d = (op == DIV) || (op == DIVU);
            sign_a_d = sa_c;
            sign_b_d = sb_c;
            cnt_d    = '0;
            acc_d    = '0;
            // Divide shifts the dividend out of mq; multiply consumes the multiplier.
            mq_d     = is_div_d ? mag_a_c : mag_b_c;
            opnd_d   = is_div_d ? mag_b_c : mag_a_c;
            state_d  = RUN;
          end
        end
      end

      RUN: begin
        if (cancel_c) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc_c;
          mq_d  = is_div_q ? {mq_q[WIDTH-2:0], step_bit_c}
                           : {step_bit_c, mq_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!cancel_c) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Remainder follows the dividend; with a zero divisor it is the dividend itself.
            hi_d   = sign_a_q ? (WIDTH'(0) - acc_q) : acc_q;
            div0_d = (opnd_q == '0);
            if (opnd_q == '0) begin
              lo_d = '1;
            end else begin
              lo_d = (sign_a_q ^ sign_b_q) ? (WIDTH'(0) - mq_q) : mq_q;
            end
          end else begin
            {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? (PW'(0) - prod_c) : prod_c;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      opnd_q     <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div0_q     <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      opnd_q     <= opnd_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div0_q     <= div0_d;
      in_ready_q <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div0     = div0_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit (WIDTH = 32).
// "edges" = rising edges after the accept edge until the edge that raises done
// (0 for MTHI/MTLO, WIDTH+1 = 33 for iterative ops).
module tb_mul_div_unit;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
`ifdef MDU_CANCEL_EN
    .cancel   (cancel),
`endif
    .div0     (div0)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          edges;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Waits for done, sampling #1 after each edge; 999 if it never comes.
  task automatic wait_done(output int edges);
    edges = 999;
    if (done) begin
      edges = 0;
    end else begin
      for (int i = 1; i <= 100; i++) begin
        @(posedge clk);
        #1;
        if (done) begin
          edges = i;
          break;
        end
      end
    end
  endtask

  // Presents one op at the next negedge; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int   edges;
    logic seen_done;

    vecs[0]  = '{MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[4]  = '{DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 33};
    vecs[5]  = '{MTLO,  32'h000000A5, 32'h00000000, 32'h12345678, 32'h000000A5, 1'b0, 0};
    vecs[6]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[7]  = '{MTHI,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h80000000, 1'b0, 0};
    vecs[8]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[9]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[10] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[11] = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 33};
    vecs[12] = '{MULT,  32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vecs[13] = '{DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33};
    vecs[14] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 33};

    rst = 1'b1; in_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi",       64'(hi),       64'h0);
    chk("reset_lo",       64'(lo),       64'h0);
    chk("reset_done",     64'(done),     64'h0);
    chk("reset_div0",     64'(div0),     64'h0);
    chk("reset_busy",     64'(busy),     64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    // Table of directed operations, issued back to back.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(edges);
      chk($sformatf("v%0d_edges", i),    64'(edges),    64'(vecs[i].edges));
      chk($sformatf("v%0d_hi", i),       64'(hi),       64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i),       64'(lo),       64'(vecs[i].lo));
      chk($sformatf("v%0d_div0", i),     64'(div0),     64'(vecs[i].div0));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'h1);
    end

    // Illegal op code is ignored.
    issue(3'd7, 32'h55555555, 32'h1);
    chk("illegal_in_ready", 64'(in_ready), 64'h1);
    chk("illegal_busy",     64'(busy),     64'h0);
    seen_done = done;
    repeat (3) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    chk("illegal_no_done",  64'(seen_done), 64'h0);
    chk("illegal_hi",       64'(hi),        64'hFFFFFFFF);

    // Operand inputs change while busy; latched values are used.
    issue(DIVU, 32'd100, 32'd7);
    chk("busy_during_run",  64'(busy),     64'h1);
    chk("ready_during_run", 64'(in_ready), 64'h0);
    src_a = 32'hFFFF0000; src_b = 32'h0;
    wait_done(edges);
    chk("latched_edges", 64'(edges), 64'd33);
    chk("latched_lo",    64'(lo),    64'd14);
    chk("latched_hi",    64'(hi),    64'd2);
    chk("latched_div0",  64'(div0),  64'h0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'h0);

    // Reset pulsed mid-multiply aborts without done.
    issue(MULT, 32'h00001234, 32'h00005678);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_hi",   64'(hi),   64'h0);
    chk("midrst_lo",   64'(lo),   64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    chk("midrst_no_done",  64'(seen_done), 64'h0);
    chk("midrst_in_ready", 64'(in_ready),  64'h1);

`ifdef MDU_CANCEL_EN
    issue(MTHI, 32'h11, 32'h0);
    issue(MTLO, 32'h22, 32'h0);
    issue(DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    chk("cancel_no_done",  64'(seen_done), 64'h0);
    chk("cancel_hi",       64'(hi),        64'h11);
    chk("cancel_lo",       64'(lo),        64'h22);
    chk("cancel_in_ready", 64'(in_ready),  64'h1);
    // cancel together with in_valid in IDLE blocks the accept.
    @(negedge clk);
    op = MTHI; src_a = 32'h99; in_valid = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cancel = 1'b0;
    chk("cancel_idle_done", 64'(done), 64'h0);
    chk("cancel_idle_hi",   64'(hi),   64'h11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit sitting beside the combinational ALU in the execute stage.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Owns the architectural HI/LO registers and also services MTHI/MTLO.
- Accepts operations over a valid/ready handshake and signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 32: operand width and width of HI and LO; minimum 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, never overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  high when the unit can accept an operation.
- op  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- src_a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- src_b  in  WIDTH  multiplier / divisor.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse: HI/LO were updated at the preceding edge.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div0  out  1  sticky until next accept: last DIV/DIVU had a zero divisor.

Behaviour:
- Reset (async, active-high): state=IDLE, hi=0, lo=0, done=0, div0=0, counter=0, busy=0, in_ready=1.
- Clocking: one clock; all state updates on the rising edge of clk.
- States:
  - IDLE: in_ready=1, busy=0.
  - RUN: in_ready=0, busy=1.
  - FIX: in_ready=0, busy=1.
- Accept: an operation is accepted on an edge where in_valid & in_ready.
  - An illegal op code is ignored: no state change, no done.
- MTHI/MTLO:
  - hi (or lo) <= src_a at the accept edge; state stays IDLE.
  - done=1 in the following cycle; div0 is cleared.
- MULT/MULTU/DIV/DIVU accept:
  - Latch operand magnitudes (absolute values for the signed ops) and both sign bits.
  - counter=0, div0 cleared, state -> RUN.
- RUN:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - counter increments each cycle; after WIDTH steps, state -> FIX.
- FIX:
  - Apply sign correction and write hi/lo; state -> IDLE.
  - done=1 in the next cycle.
- Latency:
  - Accept at edge k; hi/lo are written at edge k+WIDTH+1; done is high in the cycle after that edge.
  - in_ready is already 1 during the done cycle, so back-to-back operations are allowed.
- Multiply: {hi,lo} = full 2*WIDTH product, signed or unsigned.
- Divide:
  - lo = quotient, truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - Quotient is negative iff the operand signs differ.
- Divide by zero (either signedness): lo = all ones, hi = src_a as captured, div0=1. Latency is unchanged.
- Signed overflow, -2^(WIDTH-1) / -1: lo = 0x8000_0000 (for WIDTH=32), hi = 0. No flag is raised.
- Operand inputs are ignored while busy; the values latched at accept are the ones used.
- Reset asserted mid-operation: immediate abort to reset values; no done.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel high at an edge while in RUN or FIX: state -> IDLE; hi/lo unchanged; no done; div0 unchanged.
  - cancel high together with in_valid in IDLE: the operation is not accepted.
- Undefined:
  - No cancel port.
  - Every accepted operation runs to completion.

Decomposition:
- Shared package mdu_defs holds:
  - op code constants: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5;
  - state encoding: IDLE, RUN, FIX.
- One natural sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: partial remainder/product, operand, mode.
  - Outputs: next partial value and quotient bit.
- The top level holds the FSM, counter, sign handling and HI/LO registers.

Test Plan:
- MULT 0xFFFFFFFF*0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; done exactly 33 cycles after the accept edge.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678, div0=1; next MTLO 0xA5 -> lo=0xA5, div0=0, done after 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- rst pulsed 10 cycles into a MULT -> hi=lo=0, no done, in_ready=1. With MDU_CANCEL_EN: cancel at cycle 10 of a DIV -> hi/lo keep their prior values, no done.
